im2col_line_feeder: RTL and testbench
=====================================

Name: im2col_line_feeder

Overview:
- Synthesizable front-end that turns a raster pixel stream into 3x3, stride-1, same-padded im2col patches.
- Issues one patch per cycle onto PORT byte lanes.
- Lanes are diagonally skewed: lane j lags lane 0 by j cycles.
- Sits directly upstream of the systolic array input ports and replaces the behavioural input-feature buffer in synthesis.
- Uses two line buffers plus a 3x3xCHANNEL window.

Parameters:
- WIDTH, 128, image width in pixels (>=2).
- HEIGHT, 128, image height in pixels (>=2).
- CHANNEL, 3, channels per pixel; c=0 R, 1 G, 2 B.
- BITWIDTH, 8, output lane width.
- PORT, 27, lane count; must equal 9*CHANNEL, otherwise elaboration fatal.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_pixel  input  [CHANNEL-1:0][7:0]  one pixel, top row first, left to right.
- i_valid  input  1  pixel present.
- i_ready  output  1  pixel accepted when i_valid && i_ready.
- o_data  output  [PORT-1:0][BITWIDTH-1:0]  skewed patch lanes.
- o_valid  output  [PORT-1:0]  per-lane valid.
- o_frame_done  output  1  one-cycle pulse after the last lane of the last patch.

Behaviour:
- Reset (rst=0, async): state IDLE, counters 0, window and skew pipes cleared.
  - o_data=0, o_valid=0, o_frame_done=0, i_ready=0 while asserted; i_ready=1 from the first edge after release.
  - Line-buffer RAM contents need not be cleared.
  - Reset mid-frame abandons the frame; the next accepted pixel is (0,0).
- Lane mapping: lane 9*c+k carries channel c of neighbour k, row-major 3x3 (k=0 up-left ... 4 centre ... 8 down-right).
- Padding: a neighbour outside the image gives 0 (y=0 for k=0..2, y=HEIGHT-1 for k=6..8, x=0 for k=0,3,6, x=WIDTH-1 for k=2,5,8).
- Width rule:
  - BITWIDTH>=8: zero-extend the byte.
  - BITWIDTH<8: output byte[7 -: BITWIDTH] (truncate LSBs).
- Raster index: r = WIDTH*y + x over accepted pixels only. Patch p (centre at raster p) becomes issuable once pixel r=p+WIDTH+1 is accepted.
- FSM:
  - IDLE: i_ready=1. The first accept moves to FILL with r=1.
  - FILL: i_ready=1, no issue. On the accept of r=WIDTH+1, issue patch 0 and go to RUN.
  - RUN: i_ready=1. Each accept issues patch r-(WIDTH+1); cycles without an accept issue nothing (bubble). The accept of r=WIDTH*HEIGHT-1 issues its patch and goes to FLUSH.
  - FLUSH: i_ready=0. Issues the remaining WIDTH+1 patches, one per consecutive cycle without gaps, then goes to IDLE.
- Timing: a patch issued due to an accept in cycle t appears on lane 0 at t+1 and on lane j at t+1+j. A FLUSH issue in cycle t behaves the same.
- Bubbles: a bubble gives o_valid[j]=0 and o_data[j]=0 at the corresponding skewed cycle.
- Skew pipe: free-running, never stalls. A new frame may enter IDLE/FILL while the previous frame's skew pipe is still draining; no interaction between frames.
- o_frame_done: pulses in the cycle after the last patch's value leaves lane PORT-1, i.e. PORT cycles after the final FLUSH issue cycle.
- Storage: 2 line buffers of WIDTH*CHANNEL bytes, written at column x on every accept. Read and write to the same address in one cycle returns the old data.

Test Plan:
- Setup for the first four scenarios: WIDTH=4, HEIGHT=3, CHANNEL=1, PORT=9. Stream pixel values 1..12 back-to-back.
  - Response: lane 0 first valid the cycle after the 6th accept, carrying patch 0 = {0,0,0,0,1,2,0,5,6}.
  - Lane 8 shows 6 eight cycles later.
- Same stream, frame tail:
  - i_ready is low for exactly 5 cycles after the 12th accept.
  - Last patch = {7,8,0,11,12,0,0,0,0}.
  - o_frame_done pulses 9 cycles after the last FLUSH issue.
- Same stream with i_valid low 2 cycles after pixel 7:
  - Lane 0 shows 2 invalid zero cycles between patch 1 and patch 2.
  - Lane j shows the same gap j cycles later; all values unchanged.
- Same setup, reset mid-frame: assert rst after pixel 8 (async, mid-cycle).
  - All o_valid drop immediately.
  - A new 12-pixel frame produces patches identical to the first scenario.
- Default 128x128x3 with a random image: every lane sequence matches the software im2col golden model with skew j. Also run back-to-back frames with no idle cycle.
- BITWIDTH=4, single pixel value 0xAB:
  - Centre lane outputs 0xA.
  - BITWIDTH=12 outputs 0x0AB.

Source files
------------

// File: rtl/im2col_line_feeder.sv
// Raster pixel stream to 3x3 stride-1 same-padded im2col patches, one patch per accept/flush cycle.
// Latency: lane j of a patch appears 1+j cycles after the cycle that issues it (diagonal skew).
// Backpressure: i_ready drops only for the WIDTH+1 flush cycles; the skew pipe never stalls.
module im2col_line_feeder #(
    parameter int WIDTH    = 128,
    parameter int HEIGHT   = 128,
    parameter int CHANNEL  = 3,
    parameter int BITWIDTH = 8,
    parameter int PORT     = 27
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CHANNEL-1:0][7:0]            i_pixel,
    input  logic                               i_valid,
    output logic                               i_ready,
    output logic [PORT-1:0][BITWIDTH-1:0]      o_data,
    output logic [PORT-1:0]                    o_valid,
    output logic                               o_frame_done
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT + 2);

    if (PORT != 9 * CHANNEL) begin : g_bad_port
        $fatal(1, "im2col_line_feeder: PORT must equal 9*CHANNEL");
    end

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
    state_t state, state_nxt;

    logic                              ready_en;
    logic [XW-1:0]                     x, px;
    logic [YW-1:0]                     y, py;
    logic                              accept, step, issue, last_issue;
    logic                              fill_end, last_pix, flush_end;
    logic [CHANNEL-1:0][7:0]           pix_in, lb0_rd, lb1_rd;
    logic [CHANNEL-1:0][7:0]           lb0 [WIDTH];
    logic [CHANNEL-1:0][7:0]           lb1 [WIDTH];
    logic [2:0][1:0][CHANNEL-1:0][7:0] win;
    logic [2:0][2:0][CHANNEL-1:0][7:0] win_full;
    logic [PORT-1:0][7:0]              patch_byte;
    logic [PORT-1:0][BITWIDTH-1:0]     patch;
    logic [PORT-1:0]                   vld_sr, last_sr;
    logic                              top_pad, bot_pad, lft_pad, rgt_pad;

    assign i_ready   = ready_en && (state != FLUSH);
    assign accept    = i_valid && i_ready;
    assign step      = accept || (state == FLUSH);
    assign fill_end  = (y == YW'(1)) && (x == XW'(1));
    assign last_pix  = (y == YW'(HEIGHT - 1)) && (x == XW'(WIDTH - 1));
    assign flush_end = (py == YW'(HEIGHT - 1)) && (px == XW'(WIDTH - 1));
    // Flush shifts in a zero row below the image; it is always masked by bottom padding.
    assign pix_in    = (state == FLUSH) ? '0 : i_pixel;
    assign lb0_rd    = lb0[x];
    assign lb1_rd    = lb1[x];

    assign top_pad = (py == '0);
    assign bot_pad = (py == YW'(HEIGHT - 1));
    assign lft_pad = (px == '0);
    assign rgt_pad = (px == XW'(WIDTH - 1));

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        last_issue = 1'b0;
        case (state)
            IDLE:  if (accept) state_nxt = FILL;
            FILL:  if (accept && fill_end) begin
                       issue     = 1'b1;
                       state_nxt = last_pix ? FLUSH : RUN;
                   end
            RUN:   if (accept) begin
                       issue = 1'b1;
                       if (last_pix) state_nxt = FLUSH;
                   end
            FLUSH: begin
                       issue = 1'b1;
                       if (flush_end) begin
                           last_issue = 1'b1;
                           state_nxt  = IDLE;
                       end
                   end
            default: state_nxt = IDLE;
        endcase
    end

    // Window columns 0/1 are registered; column 2 is the column being shifted in this cycle.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_full[r][0] = win[r][0];
            win_full[r][1] = win[r][1];
        end
        win_full[0][2] = lb1_rd;
        win_full[1][2] = lb0_rd;
        win_full[2][2] = pix_in;
    end

    always_comb begin
        patch_byte = '0;
        for (int c = 0; c < CHANNEL; c++) begin
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    if (!((r == 0 && top_pad) || (r == 2 && bot_pad) ||
                          (k == 0 && lft_pad) || (k == 2 && rgt_pad)))
                        patch_byte[9*c + 3*r + k] = win_full[r][k][c];
                end
            end
        end
    end

    for (genvar j = 0; j < PORT; j++) begin : g_fit
        if (BITWIDTH >= 8) begin : g_ext
            assign patch[j] = BITWIDTH'(patch_byte[j]);
        end else begin : g_trunc
            assign patch[j] = patch_byte[j][7 -: BITWIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ready_en <= 1'b0;
            x        <= '0;
            y        <= '0;
            px       <= '0;
            py       <= '0;
            win      <= '0;
            vld_sr   <= '0;
            last_sr  <= '0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
            vld_sr   <= {vld_sr[PORT-2:0], issue};
            last_sr  <= {last_sr[PORT-2:0], last_issue};
            if (step) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win_full[r][1];
                    win[r][1] <= win_full[r][2];
                end
            end
            if (last_issue) begin
                x  <= '0;
                y  <= '0;
                px <= '0;
                py <= '0;
            end else begin
                if (step) begin
                    if (x == XW'(WIDTH - 1)) begin
                        x <= '0;
                        y <= y + 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
                if (issue) begin
                    if (px == XW'(WIDTH - 1)) begin
                        px <= '0;
                        py <= py + 1'b1;
                    end else begin
                        px <= px + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (step) begin
            lb0[x] <= pix_in;
            lb1[x] <= lb0_rd;
        end
    end

    for (genvar j = 0; j < PORT; j++) begin : g_lane
        logic [BITWIDTH-1:0] dly [j+1];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int d = 0; d <= j; d++) dly[d] <= '0;
            end else begin
                dly[0] <= issue ? patch[j] : '0;
                for (int d = 1; d <= j; d++) dly[d] <= dly[d-1];
            end
        end
        assign o_data[j] = dly[j];
    end

    assign o_valid      = vld_sr;
    assign o_frame_done = last_sr[PORT-1];
endmodule

// File: tb/tb_im2col_line_feeder.sv
// Scoreboard bench: small 4x3x1 frames (bubbles, tail, mid-frame reset) and random 5x4x3 BITWIDTH=4 back-to-back frames.
module tb_im2col_line_feeder;
    localparam int WA = 4, HA = 3, PA = 9;
    localparam int WB = 5, HB = 4, CB = 3, PB = 27, BWB = 4;

    typedef struct {
        int t;
        int v;
    } ent_t;

    logic clk, rst_a, rst_b;
    logic [0:0][7:0]        a_ipix;
    logic                   a_ivld, a_irdy, a_done;
    logic [PA-1:0][7:0]     a_odat;
    logic [PA-1:0]          a_ovld;
    logic [CB-1:0][7:0]     b_ipix;
    logic                   b_ivld, b_irdy, b_done;
    logic [PB-1:0][BWB-1:0] b_odat;
    logic [PB-1:0]          b_ovld;

    int   cyc = 0;
    int   n_chk = 0, n_pass = 0;
    int   img_a [WA*HA];
    logic [CB-1:0][7:0] img_b [WB*HB];
    ent_t qa [PA][$];
    ent_t qb [PB][$];
    int   fda [$];
    int   fdb [$];

    im2col_line_feeder #(.WIDTH(WA), .HEIGHT(HA), .CHANNEL(1), .BITWIDTH(8), .PORT(PA)) u_dut_a (
        .clk(clk), .rst(rst_a), .i_pixel(a_ipix), .i_valid(a_ivld), .i_ready(a_irdy),
        .o_data(a_odat), .o_valid(a_ovld), .o_frame_done(a_done));

    im2col_line_feeder #(.WIDTH(WB), .HEIGHT(HB), .CHANNEL(CB), .BITWIDTH(BWB), .PORT(PB)) u_dut_b (
        .clk(clk), .rst(rst_b), .i_pixel(b_ipix), .i_valid(b_ivld), .i_ready(b_irdy),
        .o_data(b_odat), .o_valid(b_ovld), .o_frame_done(b_done));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int exp_a(int p, int lane);
        int k  = lane % 9;
        int ny = p / WA + k / 3 - 1;
        int nx = p % WA + k % 3 - 1;
        if (ny < 0 || ny >= HA || nx < 0 || nx >= WA) return 0;
        return img_a[ny*WA + nx];
    endfunction

    function automatic int exp_b(int p, int lane);
        int c  = lane / 9;
        int k  = lane % 9;
        int ny = p / WB + k / 3 - 1;
        int nx = p % WB + k % 3 - 1;
        logic [7:0] bv;
        if (ny < 0 || ny >= HB || nx < 0 || nx >= WB) return 0;
        bv = img_b[ny*WB + nx][c];
        return int'(bv >> 4);
    endfunction

    task automatic push_a(input int p, input int t);
        ent_t e;
        for (int j = 0; j < PA; j++) begin
            e.t = t + 1 + j;
            e.v = exp_a(p, j);
            qa[j].push_back(e);
        end
    endtask

    task automatic push_b(input int p, input int t);
        ent_t e;
        for (int j = 0; j < PB; j++) begin
            e.t = t + 1 + j;
            e.v = exp_b(p, j);
            qb[j].push_back(e);
        end
    endtask

    // An accept of raster r in cycle k issues patch r-W-1 in k; the last pixel also schedules the flush.
    task automatic acc_a(input int r, input int k);
        if (r >= WA + 1) push_a(r - WA - 1, k);
        if (r == WA*HA - 1) begin
            for (int i = 1; i <= WA + 1; i++) push_a(r - WA - 1 + i, k + i);
            fda.push_back(k + WA + 1 + PA);
        end
    endtask

    task automatic acc_b(input int r, input int k);
        if (r >= WB + 1) push_b(r - WB - 1, k);
        if (r == WB*HB - 1) begin
            for (int i = 1; i <= WB + 1; i++) push_b(r - WB - 1 + i, k + i);
            fdb.push_back(k + WB + 1 + PB);
        end
    endtask

    task automatic frame_a(input int gap_after, input int gap_len, input int n_pix);
        int r = 0;
        int guard = 0;
        while (r < n_pix && guard < 200) begin
            @(negedge clk);
            guard++;
            a_ivld = 1'b1;
            a_ipix[0] = 8'(img_a[r]);
            if (a_irdy) begin
                acc_a(r, cyc);
                r++;
                if (r == gap_after) begin
                    repeat (gap_len) begin
                        @(negedge clk);
                        a_ivld = 1'b0;
                    end
                end
            end
        end
        if (r < n_pix) chk("a_accept_timeout", r, n_pix);
    endtask

    task automatic tail_a();
        for (int i = 0; i < WA + 1; i++) begin
            @(negedge clk);
            a_ivld = 1'b0;
            chk("a_flush_rdy_low", a_irdy, 0);
        end
        @(negedge clk);
        chk("a_idle_rdy_high", a_irdy, 1);
    endtask

    task automatic frames_b(input int nf);
        for (int f = 0; f < nf; f++) begin
            int r = 0;
            int guard = 0;
            for (int i = 0; i < WB*HB; i++)
                for (int c = 0; c < CB; c++) img_b[i][c] = 8'($urandom);
            if (f == 0) img_b[WB + 1][0] = 8'hAB;
            while (r < WB*HB && guard < 1000) begin
                @(negedge clk);
                guard++;
                b_ivld = (r == 0) || ($urandom_range(0, 3) != 0);
                b_ipix = img_b[r];
                if (b_ivld && b_irdy) begin
                    acc_b(r, cyc);
                    r++;
                end
            end
            if (r < WB*HB) chk("b_accept_timeout", r, WB*HB);
        end
        @(negedge clk);
        b_ivld = 1'b0;
    endtask

    always @(negedge clk) begin
        for (int j = 0; j < PA; j++) begin
            if (qa[j].size() > 0 && qa[j][0].t == cyc) begin
                chk($sformatf("a_vld[%0d]", j), a_ovld[j], 1);
                chk($sformatf("a_dat[%0d]", j), a_odat[j], qa[j][0].v);
                void'(qa[j].pop_front());
            end else begin
                chk($sformatf("a_bubble_vld[%0d]", j), a_ovld[j], 0);
                chk($sformatf("a_bubble_dat[%0d]", j), a_odat[j], 0);
            end
        end
        if (fda.size() > 0 && fda[0] == cyc) begin
            chk("a_frame_done", a_done, 1);
            void'(fda.pop_front());
        end else chk("a_no_frame_done", a_done, 0);
    end

    always @(negedge clk) begin
        for (int j = 0; j < PB; j++) begin
            if (qb[j].size() > 0 && qb[j][0].t == cyc) begin
                chk($sformatf("b_vld[%0d]", j), b_ovld[j], 1);
                chk($sformatf("b_dat[%0d]", j), b_odat[j], qb[j][0].v);
                void'(qb[j].pop_front());
            end else begin
                chk($sformatf("b_bubble_vld[%0d]", j), b_ovld[j], 0);
                chk($sformatf("b_bubble_dat[%0d]", j), b_odat[j], 0);
            end
        end
        if (fdb.size() > 0 && fdb[0] == cyc) begin
            chk("b_frame_done", b_done, 1);
            void'(fdb.pop_front());
        end else chk("b_no_frame_done", b_done, 0);
    end

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        a_ivld = 1'b0;
        a_ipix = '0;
        b_ivld = 1'b0;
        b_ipix = '0;
        for (int i = 0; i < WA*HA; i++) img_a[i] = i + 1;
        #1;
        chk("a_rst_ready", a_irdy, 0);
        chk("a_rst_valid", a_ovld, 0);
        chk("a_rst_data", |a_odat, 0);
        chk("a_rst_done", a_done, 0);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        chk("a_ready_after_rst", a_irdy, 1);

        frame_a(0, 0, WA*HA);
        tail_a();
        repeat (12) @(negedge clk);

        frame_a(7, 2, WA*HA);
        tail_a();
        repeat (12) @(negedge clk);

        frame_a(0, 0, 8);
        @(negedge clk);
        a_ivld = 1'b0;
        #2;
        rst_a = 1'b0;
        for (int j = 0; j < PA; j++) qa[j].delete();
        fda.delete();
        #1;
        chk("a_midrst_valid", a_ovld, 0);
        chk("a_midrst_data", |a_odat, 0);
        chk("a_midrst_ready", a_irdy, 0);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        chk("a_ready_after_midrst", a_irdy, 1);
        frame_a(0, 0, WA*HA);
        tail_a();

        frames_b(2);
        repeat (60) @(negedge clk);
        for (int j = 0; j < PA; j++) chk($sformatf("a_drained[%0d]", j), qa[j].size(), 0);
        for (int j = 0; j < PB; j++) chk($sformatf("b_drained[%0d]", j), qb[j].size(), 0);
        chk("a_done_drained", fda.size(), 0);
        chk("b_done_drained", fdb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
